axi_mem_init_engine: RTL and testbench

//  Parametrised, synthesisable successor of the simulation memory initialiser.
//  - Accepts (addr, len, payload) write commands on a valid/ready stream and buffers them in a command FIFO.
//  - Turns each command into AXI4 INCR write bursts: 1 or 2 beats, split at 4KB boundaries.
//  - Keeps up to MAX_OUTSTANDING writes in flight.
//  - Asserts init_done once the last command is fully acknowledged on the B channel.
//  - Sits between the host/DMA preload path and the device or system memory AXI slave.

---
 rtl/axi_mem_init_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_mem_init_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_init_engine.sv
// axi_mem_init_engine
//   Buffers (addr, len, payload) write commands in a small FIFO and turns each
//   one into AXI4 INCR write bursts of one or two beats.  A two-beat command
//   whose second beat starts on a 4KB page is issued as two one-beat bursts.
//   Up to MAX_OUTSTANDING bursts may await their B response.  init_done rises
//   once the command flagged s_cmd_last and everything before it is acknowledged.
//
// Ports
//   axis_clk, axis_rst     clock, synchronous active-high reset
//   s_cmd_*                command stream (valid/ready, addr, len, data, last)
//   m_axi_aw*/w*/b*        AXI4 write channels (awid tied 0, bready held 1)
//   init_done              sticky completion flag
//   cmd_err                sticky: an illegal command was dropped
//   resp_err               sticky: a non-OKAY bresp was received
//
// Build option
//   AXI_INIT_STATS_EN      adds saturating counters stat_cmd_cnt, stat_beat_cnt,
//                          stat_err_cnt
module axi_mem_init_engine #(
    parameter int DATA_W          = 512,
    parameter int ADDR_W          = 64,
    parameter int LEN_W           = 16,
    parameter int ID_W            = 4,
    parameter int CMD_DEPTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [ADDR_W-1:0]     s_cmd_addr,
    input  logic [LEN_W-1:0]      s_cmd_len,
    input  logic [DATA_W-1:0]     s_cmd_data,
    input  logic                  s_cmd_last,
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
`ifdef AXI_INIT_STATS_EN
    output logic [31:0]           stat_cmd_cnt,
    output logic [31:0]           stat_beat_cnt,
    output logic [15:0]           stat_err_cnt,
`endif
    output logic                  init_done,
    output logic                  cmd_err,
    output logic                  resp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int ENT_W = ADDR_W + LEN_W + DATA_W;

    typedef enum logic [1:0] {IDLE, AW, W, DONE} state_t;

    function automatic logic [BYTES-1:0] lane_range(input int lo, input int hi);
        logic [BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES; i++) m[i] = (i >= lo) && (i < hi);
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] expand_strb(input logic [BYTES-1:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    fifo_mem [CMD_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push;
    logic                last_seen;
    logic [3:0]          outst;
    logic                out_ok;
    logic                pop, drop, issue, resume;
    logic                part2_q, beat_q, end_beat_q, wlast_c;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [OFF_W-1:0]    wk_off;
    logic [LEN_W-1:0]    wk_len;
    logic [DATA_W-1:0]   wk_data;
    logic                aw_hs, w_hs, b_hs;

    // FIFO head decode: burst shape of the next command
    logic [ENT_W-1:0]    head;
    logic [ADDR_W-1:0]   h_addr, h_base, h_next;
    logic [LEN_W-1:0]    h_len;
    logic [DATA_W-1:0]   h_data;
    logic [OFF_W-1:0]    h_off;
    logic [LEN_W:0]      h_end;
    logic                h_bad, h_two, h_cross;

    assign head    = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign h_addr  = head[ENT_W-1 -: ADDR_W];
    assign h_len   = head[DATA_W+LEN_W-1 -: LEN_W];
    assign h_data  = head[DATA_W-1:0];
    assign h_off   = h_addr[OFF_W-1:0];
    assign h_base  = {h_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign h_next  = h_base + ADDR_W'(BYTES);
    assign h_end   = {1'b0, h_len} + (LEN_W+1)'(h_off);
    assign h_bad   = (h_len == '0) || (h_end > (LEN_W+1)'(2*BYTES));
    assign h_two   = h_end > (LEN_W+1)'(BYTES);
    // second beat landing on a 4KB page start must go out as its own burst
    assign h_cross = h_two && (h_next[11:0] == 12'd0);

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign s_cmd_ready = !fifo_full && !last_seen;
    assign push        = s_cmd_valid && s_cmd_ready;
    assign out_ok      = outst < 4'(MAX_OUTSTANDING);
    assign wlast_c     = (beat_q == end_beat_q);
    assign aw_hs       = m_axi_awvalid && m_axi_awready;
    assign w_hs        = m_axi_wvalid && m_axi_wready;
    // a stray B with nothing outstanding is ignored entirely
    assign b_hs        = m_axi_bvalid && (outst != 4'd0);

    logic unused_bid;
    assign unused_bid = ^m_axi_bid;

    // write-beat lane strobes and data, built from the working command
    int                  wk_sum;
    logic [BYTES-1:0]    strb0, strb1;
    logic [DATA_W-1:0]   data0, data1;

    always_comb begin
        wk_sum = int'(wk_off) + int'(wk_len);
        strb0  = lane_range(int'(wk_off), (wk_sum < BYTES) ? wk_sum : BYTES);
        strb1  = lane_range(0, wk_sum - BYTES);
        data0  = (wk_data << (int'(wk_off) * 8)) & expand_strb(strb0);
        data1  = (wk_data >> ((BYTES - int'(wk_off)) * 8)) & expand_strb(strb1);
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        drop    = 1'b0;
        issue   = 1'b0;
        resume  = 1'b0;
        case (state_q)
            IDLE: begin
                if (part2_q) begin
                    if (out_ok) begin
                        resume  = 1'b1;
                        state_d = AW;
                    end
                end else if (!fifo_empty) begin
                    if (h_bad) begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end else if (out_ok) begin
                        pop     = 1'b1;
                        issue   = 1'b1;
                        state_d = AW;
                    end
                end else if (last_seen && outst == 4'd0) begin
                    state_d = DONE;
                end
            end
            AW:      if (m_axi_awready) state_d = W;
            W:       if (m_axi_wready && wlast_c) state_d = IDLE;
            default: state_d = DONE;
        endcase
    end

    always_comb begin
        m_axi_awid    = '0;
        m_axi_awaddr  = aw_addr_q;
        m_axi_awlen   = {7'd0, end_beat_q & ~beat_q};
        m_axi_awsize  = 3'(OFF_W);
        m_axi_awburst = 2'b01;
        m_axi_awvalid = (state_q == AW);
        m_axi_wdata   = beat_q ? data1 : data0;
        m_axi_wstrb   = beat_q ? strb1 : strb0;
        m_axi_wlast   = wlast_c;
        m_axi_wvalid  = (state_q == W);
        m_axi_bready  = 1'b1;
        init_done     = (state_q == DONE);
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_seen  <= 1'b0;
            outst      <= 4'd0;
            cmd_err    <= 1'b0;
            resp_err   <= 1'b0;
            part2_q    <= 1'b0;
            beat_q     <= 1'b0;
            end_beat_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (s_cmd_last) last_seen <= 1'b1;
            end
            if (pop)  rd_ptr  <= rd_ptr + 1'b1;
            if (drop) cmd_err <= 1'b1;
            if (issue) begin
                beat_q     <= 1'b0;
                end_beat_q <= h_two && !h_cross;
                part2_q    <= h_cross;
            end else if (resume) begin
                part2_q    <= 1'b0;
                beat_q     <= 1'b1;
                end_beat_q <= 1'b1;
            end else if (w_hs && !wlast_c) begin
                beat_q     <= 1'b1;
            end
            if (aw_hs && !b_hs)      outst <= outst + 4'd1;
            else if (!aw_hs && b_hs) outst <= outst - 4'd1;
            if (b_hs && m_axi_bresp != 2'b00) resp_err <= 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {s_cmd_addr, s_cmd_len, s_cmd_data};
        if (issue) begin
            aw_addr_q <= h_base;
            wk_off    <= h_off;
            wk_len    <= h_len;
            wk_data   <= h_data;
        end else if (resume) begin
            aw_addr_q <= aw_addr_q + ADDR_W'(BYTES);
        end
    end

`ifdef AXI_INIT_STATS_EN
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            stat_cmd_cnt  <= '0;
            stat_beat_cnt <= '0;
            stat_err_cnt  <= '0;
        end else begin
            if (issue && stat_cmd_cnt != '1)  stat_cmd_cnt  <= stat_cmd_cnt + 1'b1;
            if (w_hs && stat_beat_cnt != '1)  stat_beat_cnt <= stat_beat_cnt + 1'b1;
            if (b_hs && m_axi_bresp != 2'b00 && stat_err_cnt != '1)
                stat_err_cnt <= stat_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_mem_init_engine.sv
// Testbench for axi_mem_init_engine: directed vector table, multi-cycle corner
// sequences and a randomized run scored against a byte-addressed memory model.
module tb_axi_mem_init_engine;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 16;
    localparam int ID_W   = 4;
    localparam int BYTES  = DATA_W / 8;

    logic                axis_clk = 1'b0;
    logic                axis_rst = 1'b1;
    logic                s_cmd_valid = 1'b0;
    logic                s_cmd_ready;
    logic [ADDR_W-1:0]   s_cmd_addr = '0;
    logic [LEN_W-1:0]    s_cmd_len = '0;
    logic [DATA_W-1:0]   s_cmd_data = '0;
    logic                s_cmd_last = 1'b0;
    logic [ID_W-1:0]     m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [BYTES-1:0]    m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [ID_W-1:0]     m_axi_bid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic                init_done, cmd_err, resp_err;
`ifdef AXI_INIT_STATS_EN
    logic [31:0]         stat_cmd_cnt, stat_beat_cnt;
    logic [15:0]         stat_err_cnt;
`endif

    always #5 axis_clk = ~axis_clk;

    axi_mem_init_engine dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_len(s_cmd_len), .s_cmd_data(s_cmd_data), .s_cmd_last(s_cmd_last),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
`ifdef AXI_INIT_STATS_EN
        .stat_cmd_cnt(stat_cmd_cnt), .stat_beat_cnt(stat_beat_cnt),
        .stat_err_cnt(stat_err_cnt),
`endif
        .init_done(init_done), .cmd_err(cmd_err), .resp_err(resp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_pct = 100, w_pct = 100, b_pct = 100;
    bit          b_hold = 0;
    logic [1:0]  bresp_val = 2'b00;
    logic [63:0] aw_addr_log[$];
    int          aw_len_log[$];
    logic [63:0] w_strb_log[$];
    logic [63:0] cur_aw_addr[$];
    int          cur_aw_len[$];
    int          beat, b_pend, aw_cnt, b_cnt, max_out, wlast_cnt;
    int          lane_bad, wlast_bad, attr_bad;
    int          aw_first_edge, b_edge;
    logic [7:0]  act_mem [logic [63:0]];

    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bid     = '0;
        forever begin
            @(negedge axis_clk);
            if (axis_rst) begin
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                aw_addr_log.delete(); aw_len_log.delete(); w_strb_log.delete();
                cur_aw_addr.delete(); cur_aw_len.delete(); act_mem.delete();
                beat = 0; b_pend = 0; aw_cnt = 0; b_cnt = 0; max_out = 0; wlast_cnt = 0;
                lane_bad = 0; wlast_bad = 0; attr_bad = 0;
                aw_first_edge = -1; b_edge = -1;
                continue;
            end
            // B is decided before W so a response never shares the edge of its wlast
            m_axi_bvalid = 1'b0;
            if (b_pend > 0 && !b_hold && $urandom_range(0, 99) < b_pct) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = bresp_val;
                b_pend--; b_cnt++;
                b_edge = cyc + 1;
            end
            m_axi_awready = ($urandom_range(0, 99) < aw_pct);
            if (m_axi_awvalid && aw_first_edge < 0) aw_first_edge = cyc + 1;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log.push_back(m_axi_awaddr);
                aw_len_log.push_back(int'(m_axi_awlen));
                cur_aw_addr.push_back(m_axi_awaddr);
                cur_aw_len.push_back(int'(m_axi_awlen));
                aw_cnt++;
                if (m_axi_awsize != 3'd6 || m_axi_awburst != 2'b01 || m_axi_awid != '0) attr_bad++;
                if (aw_cnt - b_cnt > max_out) max_out = aw_cnt - b_cnt;
            end
            m_axi_wready = ($urandom_range(0, 99) < w_pct);
            if (m_axi_wvalid && m_axi_wready) begin
                w_strb_log.push_back(64'(m_axi_wstrb));
                if (cur_aw_addr.size() == 0) begin
                    lane_bad++;
                end else begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (m_axi_wstrb[i])
                            act_mem[cur_aw_addr[0] + 64'(beat * BYTES + i)] = m_axi_wdata[i*8 +: 8];
                        else if (m_axi_wdata[i*8 +: 8] != 8'h00)
                            lane_bad++;
                    end
                    if (m_axi_wlast != (beat == cur_aw_len[0])) wlast_bad++;
                    if (m_axi_wlast) begin
                        void'(cur_aw_addr.pop_front());
                        void'(cur_aw_len.pop_front());
                        beat = 0; b_pend++; wlast_cnt++;
                    end else begin
                        beat++;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_mem [logic [63:0]];
    int         exp_aw, exp_beats, exp_cmds;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic do_reset();
        @(negedge axis_clk);
        axis_rst    = 1'b1;
        s_cmd_valid = 1'b0;
        exp_mem.delete();
        exp_aw = 0; exp_beats = 0; exp_cmds = 0;
        repeat (2) @(negedge axis_clk);
        axis_rst = 1'b0;
    endtask

    task automatic send_cmd(input logic [63:0] addr, input int len,
                            input logic [DATA_W-1:0] data, input bit last,
                            output int hs_edge);
        int          n;
        int          lines;
        logic [63:0] nxt;
        @(negedge axis_clk);
        s_cmd_valid = 1'b1;
        s_cmd_addr  = addr;
        s_cmd_len   = LEN_W'(len);
        s_cmd_data  = data;
        s_cmd_last  = last;
        hs_edge     = -1;
        n           = 0;
        while (hs_edge < 0 && n < 2000) begin
            if (s_cmd_ready) begin
                @(negedge axis_clk);
                hs_edge = cyc;
            end else begin
                @(negedge axis_clk);
                n++;
            end
        end
        s_cmd_valid = 1'b0;
        if (hs_edge < 0) check("cmd_accept_timeout", 0, 1);
        if (len > 0 && len <= BYTES) begin
            for (int k = 0; k < len; k++) exp_mem[addr + 64'(k)] = data[k*8 +: 8];
            lines = int'(((addr + 64'(len) - 1) >> 6) - (addr >> 6)) + 1;
            nxt   = ((addr >> 6) + 1) << 6;
            exp_beats += lines;
            exp_aw    += (lines == 2 && nxt[11:0] == 12'd0) ? 2 : 1;
            exp_cmds++;
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int done_edge);
        int n = 0;
        while (!init_done && n < budget) begin
            @(negedge axis_clk);
            n++;
        end
        done_edge = cyc;
        check({tag, "_init_done"}, init_done, 1);
    endtask

    task automatic check_mem(input string tag);
        int mism = 0;
        foreach (exp_mem[a])
            if (!act_mem.exists(a) || act_mem[a] !== exp_mem[a]) mism++;
        check({tag, "_mem_mismatch"}, mism, 0);
        check({tag, "_mem_bytes"}, act_mem.num(), exp_mem.num());
        check({tag, "_lane_zero"}, lane_bad, 0);
        check({tag, "_wlast"}, wlast_bad, 0);
        check({tag, "_aw_attr"}, attr_bad, 0);
    endtask

    typedef struct {
        logic [63:0] addr;
        int          len;
        int          n_aw;
        logic [63:0] aw0;
        int          len0;
        logic [63:0] aw1;
        logic [63:0] strb0;
        logic [63:0] strb1;
    } vec_t;

    initial begin
        vec_t        vt[6];
        int          hs, de, nb;
        string       t;
        logic [63:0] a;

        vt[0] = '{64'h1000, 64, 1, 64'h1000, 0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vt[1] = '{64'h2030, 32, 1, 64'h2000, 1, 64'h0,    64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_FFFF};
        vt[2] = '{64'h0FF0, 64, 2, 64'h0FC0, 0, 64'h1000, 64'hFFFF_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF};
        vt[3] = '{64'h3005,  1, 1, 64'h3000, 0, 64'h0,    64'h0000_0000_0000_0020, 64'h0};
        vt[4] = '{64'h403F,  2, 1, 64'h4000, 1, 64'h0,    64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        vt[5] = '{64'h1FFF, 64, 2, 64'h1FC0, 0, 64'h2000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

        do_reset();
        @(negedge axis_clk);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_bready", m_axi_bready, 1);
        check("rst_cmd_ready", s_cmd_ready, 1);

        for (int r = 0; r < 6; r++) begin
            t = $sformatf("vec%0d", r);
            do_reset();
            send_cmd(vt[r].addr, vt[r].len, rand_data(), 1'b1, hs);
            wait_done(t, 300, de);
            check({t, "_aw_latency"}, aw_first_edge - hs, 2);
            check({t, "_done_latency"}, de - b_edge, 1);
            check({t, "_n_aw"}, aw_cnt, vt[r].n_aw);
            check({t, "_aw0"}, (aw_addr_log.size() > 0) ? aw_addr_log[0] : 64'hDEAD, vt[r].aw0);
            check({t, "_awlen0"}, (aw_len_log.size() > 0) ? aw_len_log[0] : -1, vt[r].len0);
            if (vt[r].n_aw == 2)
                check({t, "_aw1"}, (aw_addr_log.size() > 1) ? aw_addr_log[1] : 64'hDEAD, vt[r].aw1);
            nb = (vt[r].n_aw == 2) ? 2 : vt[r].len0 + 1;
            check({t, "_n_beats"}, w_strb_log.size(), nb);
            check({t, "_strb0"}, (w_strb_log.size() > 0) ? w_strb_log[0] : 64'hDEAD, vt[r].strb0);
            if (nb == 2)
                check({t, "_strb1"}, (w_strb_log.size() > 1) ? w_strb_log[1] : 64'hDEAD, vt[r].strb1);
            check({t, "_wlast_cnt"}, wlast_cnt, vt[r].n_aw);
            check({t, "_ready_after_last"}, s_cmd_ready, 0);
            check_mem(t);
        end

        // outstanding limit: B channel withheld
        do_reset();
        b_hold = 1;
        for (int i = 0; i < 8; i++)
            send_cmd(64'h10000 + 64'(i * 64), 64, rand_data(), i == 7, hs);
        repeat (200) @(negedge axis_clk);
        check("bp_aw_stalled", aw_cnt, 4);
        check("bp_w_done", wlast_cnt, 4);
        check("bp_no_done", init_done, 0);
        b_hold = 0;
        wait_done("bp", 2000, de);
        check("bp_aw_total", aw_cnt, 8);
        check("bp_max_out", max_out, 4);
        check_mem("bp");

        // dropped command and error response
        do_reset();
        send_cmd(64'h20000, 0, rand_data(), 1'b0, hs);
        repeat (10) @(negedge axis_clk);
        check("err_cmd_err", cmd_err, 1);
        check("err_no_aw", aw_cnt, 0);
        bresp_val = 2'b10;
        send_cmd(64'h20040, 16, rand_data(), 1'b1, hs);
        wait_done("err", 300, de);
        check("err_resp_err", resp_err, 1);
        check("err_cmd_err_sticky", cmd_err, 1);
        check("err_aw_cnt", aw_cnt, 1);
        check_mem("err");
        bresp_val = 2'b00;

        // reset while a write beat is stalled
        do_reset();
        w_pct = 0;
        send_cmd(64'h30000, 64, rand_data(), 1'b0, hs);
        begin
            int n = 0;
            while (!m_axi_wvalid && n < 50) begin
                @(negedge axis_clk);
                n++;
            end
        end
        check("mid_wvalid_seen", m_axi_wvalid, 1);
        axis_rst = 1'b1;
        @(negedge axis_clk);
        check("mid_rst_awvalid", m_axi_awvalid, 0);
        check("mid_rst_wvalid", m_axi_wvalid, 0);
        check("mid_rst_init_done", init_done, 0);
        check("mid_rst_bready", m_axi_bready, 1);
        do_reset();
        w_pct = 100;
        send_cmd(64'h31000, 40, rand_data(), 1'b1, hs);
        wait_done("mid", 300, de);
        check("mid_aw_cnt", aw_cnt, 1);
        check_mem("mid");

        // randomized traffic with random slave stalls
        do_reset();
        aw_pct = 60; w_pct = 60; b_pct = 35;
        for (int k = 0; k < 24; k++) begin
            a = 64'h10_0000 + 64'(k) * 64'h2000 + 64'h1000 - 64'($urandom_range(0, 127));
            send_cmd(a, $urandom_range(1, BYTES), rand_data(), k == 23, hs);
            repeat ($urandom_range(0, 3)) @(negedge axis_clk);
        end
        wait_done("rnd", 20000, de);
        check("rnd_aw_cnt", aw_cnt, exp_aw);
        check("rnd_bursts_done", wlast_cnt, exp_aw);
        check("rnd_beats", w_strb_log.size(), exp_beats);
        check("rnd_max_out_ok", max_out <= 4, 1);
        check("rnd_resp_err", resp_err, 0);
        check("rnd_cmd_err", cmd_err, 0);
        check_mem("rnd");
`ifdef AXI_INIT_STATS_EN
        check("rnd_stat_cmd", stat_cmd_cnt, exp_cmds);
        check("rnd_stat_beat", stat_beat_cnt, exp_beats);
        check("rnd_stat_err", stat_err_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
